mig_port_tester: RTL
====================

# mig_port_tester

Parametrised traffic generator and checker for one MCB user port (command, write-FIFO and read-FIFO channels). After calibration it writes a programmable region of DDR2 in fixed-length bursts, reads it back and compares against a regenerated pattern, reporting pass/fail, error count and first failing address. It runs in the `c3_clk0` domain between the `ddr_interface` user port and board-level status logic. It is the bring-up and soak-test engine for the memory path.

## Interface
- `DATA_WIDTH`, 64: user-port data width; must be a multiple of 32 (32/64/128).
- `BURST_LEN`, 16: words per command, 1..64.
- `NUM_BURSTS`, 256: bursts per pass, ≥1.
- `BASE_ADDR`, 0: first byte address; must be aligned to `BURST_LEN*DATA_WIDTH/8`.
- `TIMEOUT`, 4096: idle cycles allowed while waiting for read data.
- `clk` in 1: port clock (`c3_clk0`).
- `reset` in 1: synchronous, active-high.
- `calib_done` in 1: MCB calibration done; asynchronous, 2-flop synchronised internally.
- `start` in 1: one-cycle pulse; begins a pass.
- `continuous` in 1: sampled at `start`; 1 = loop passes until `reset`.
- `pattern_sel` in 1: sampled at `start`; 0 = address pattern, 1 = LFSR pattern.
- `cmd_en` out 1, `cmd_instr` out 3, `cmd_bl` out 6, `cmd_byte_addr` out 30, `cmd_full` in 1: command channel.
- `wr_en` out 1, `wr_data` out `DATA_WIDTH`, `wr_mask` out `DATA_WIDTH/8`, `wr_full` in 1: write channel.
- `rd_en` out 1, `rd_data` in `DATA_WIDTH`, `rd_empty` in 1: read channel (first-word-fall-through).
- `busy` out 1, `done` out 1, `pass` out 1, `timeout` out 1: status.
- `err_count` out 16: mismatching words, saturating.
- `first_err_addr` out 30: byte address of first mismatching word.

## Operation
- States: `CALIB` → `IDLE` → `FILL` → `WR_CMD` → (`FILL` | `RD_CMD`) → `DRAIN` → (`RD_CMD` | `END`) → (`IDLE` | `FILL`).
- `CALIB`: wait for synchronised `calib_done`. `IDLE`: `busy=0`; `start` latches the mode inputs, clears `err_count`/`timeout`/`done`, sets `pass=1`, sets burst index 0, seeds pattern.
- `FILL`: push `BURST_LEN` words, one per cycle, while `!wr_full`; `wr_mask` all zeros.
- `WR_CMD`: assert `cmd_en` for one cycle when `!cmd_full`; `cmd_instr=3'b000`, `cmd_bl=BURST_LEN-1`, `cmd_byte_addr=BASE_ADDR+idx*BURST_LEN*DATA_WIDTH/8`. If `idx<NUM_BURSTS-1`: increment idx, go to `FILL`; otherwise reset idx, reseed, go to `RD_CMD`.
- `RD_CMD`: same as `WR_CMD` with `cmd_instr=3'b001`. Then go to `DRAIN`.
- `DRAIN`: `rd_en = !rd_empty`; each accepted word is compared against the regenerated expected word. After `BURST_LEN` words, go to the next `RD_CMD`, or to `END` after the last burst.
- `END`: pulse `done` for one cycle. If `continuous`, go to `FILL`; otherwise go to `IDLE`. Looping passes accumulate errors; `pass` is sticky-low.
- Patterns: address pattern = 32-bit word index replicated across `DATA_WIDTH`. LFSR pattern = 32-bit Galois LFSR (taps 32,22,2,1, seed 32'hACE1_2345) stepped once per word and replicated. The pattern is reseeded at the start of each write and read phase so both phases see the same sequence.
- Mismatch handling: `pass` ← 0; `err_count` increments and saturates at 16'hFFFF; `first_err_addr` is captured only on the first error since `start`.
- Timeout: `DRAIN` with `TIMEOUT` consecutive cycles of `rd_empty` sets `timeout=1` and `pass=0`, then goes to `END` and on to `IDLE` (no loop).
- `start` is ignored unless the state is `IDLE`.

## Timing
- Reset values:
  - All strobes (`cmd_en`, `wr_en`, `rd_en`) 0.
  - `cmd_instr`, `cmd_bl`, `cmd_byte_addr`, `wr_data` 0; `wr_mask` all 0.
  - `busy=0`, `done=0`, `pass=0`, `timeout=0`, `err_count=0`, `first_err_addr=0`.
  - State `CALIB`.
- `reset` mid-pass returns to `CALIB` on the next edge with no further strobes. MCB FIFO contents are not flushed; after `reset`, the MCB is also reset.
- Calibration latency: `IDLE` is entered 3 cycles after `calib_done` rises.
- `start` in cycle n gives the first `wr_en` in cycle n+1.
- Compare result is registered: `err_count` and `first_err_addr` update in the cycle after the `rd_en` beat.
- `wr_en` is never asserted while `wr_full`; `cmd_en` is never asserted while `cmd_full`; `rd_en` is never asserted while `rd_empty`.
- Address arithmetic is 30-bit modulo (wraps at 2^30).

## Structure
- Package `mig_port_pkg`: state enum, MCB instruction constants (`INSTR_WR=3'b000`, `INSTR_RD=3'b001`), LFSR seed and tap constants.
- Sub-module `pattern_gen`: LFSR/address generator with `seed`, `step` and `sel` inputs. It is instantiated twice, once for write data and once for expected read data.

## Test plan
- Bench uses an MCB behavioural model with BURST_LEN=4 and NUM_BURSTS=3, address pattern, and models random `cmd_full`/`wr_full`/`rd_empty` back-pressure.
- Clean single pass → 3 writes at byte addresses 0, 32, 64, then 3 reads at the same addresses; `done` pulses once; `pass=1`; `err_count=0`.
- Model corrupts word 5 (bit 0 flipped) → `pass=0`, `err_count=1`, `first_err_addr=40`.
- LFSR pattern with `continuous=1` over 4 passes, no corruption → 4 `done` pulses, `pass=1`, `err_count=0`.
- Model withholds read data for the second burst → `timeout=1` after 4096 idle cycles, `pass=0`, return to `IDLE`.
- `reset` asserted during `FILL` → next cycle all strobes 0 and state `CALIB`; `start` is ignored until `calib_done` is re-synchronised.
- `start` pulsed while `busy=1` → no effect; command sequence and counts identical to the clean pass.

Source files
------------

// File: rtl/mig_port_pkg.sv
// Shared types and constants for the MCB user-port traffic generator/checker.
package mig_port_pkg;

    typedef enum logic [2:0] {
        ST_CALIB,
        ST_IDLE,
        ST_FILL,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_DRAIN,
        ST_END
    } state_t;

    localparam logic [2:0]  INSTR_WR  = 3'b000;
    localparam logic [2:0]  INSTR_RD  = 3'b001;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;
    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mig_port_tester_pattern_gen.sv
// 32-bit pattern source: incrementing word index or Galois LFSR, reseedable.
module pattern_gen
    import mig_port_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        seed,
    input  logic        step,
    input  logic        sel,
    output logic [31:0] word
);

    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (seed) begin
            word <= sel ? LFSR_SEED : '0;
        end else if (step) begin
            word <= sel ? lfsr_next(word) : word + 32'd1;
        end
    end

endmodule

// File: rtl/mig_port_tester.sv
// Writes a DDR2 region in fixed bursts through one MCB user port, reads it back
// and checks it against a regenerated pattern.
module mig_port_tester
    import mig_port_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BURSTS = 256,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          TIMEOUT    = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    calib_done,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    pattern_sel,
    output logic                    cmd_en,
    output logic [2:0]              cmd_instr,
    output logic [5:0]              cmd_bl,
    output logic [29:0]             cmd_byte_addr,
    input  logic                    cmd_full,
    output logic                    wr_en,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic                    wr_full,
    output logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_empty,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [15:0]             err_count,
    output logic [29:0]             first_err_addr
);

    localparam int WORD_BYTES  = DATA_WIDTH / 8;
    localparam int BURST_BYTES = BURST_LEN * WORD_BYTES;
    localparam int REPS        = DATA_WIDTH / 32;
    localparam int IW          = $clog2(NUM_BURSTS + 1);
    localparam int WW          = $clog2(BURST_LEN + 1);
    localparam int TW          = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_BURSTS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(BURST_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    state_t          state;
    logic            calib_s1, calib_s2;
    logic [IW-1:0]   idx;
    logic [WW-1:0]   wcnt;
    logic [TW-1:0]   to_cnt;
    logic            mode_cont, mode_lfsr;
    logic            have_err;
    logic [31:0]     wr_word, exp_word;
    logic            start_ok, loop_ok, wr_seed, rd_seed, gen_sel, mismatch;

    function automatic logic [29:0] burst_addr(input logic [IW-1:0] i);
        return 30'(BASE_ADDR) + 30'(i) * 30'(BURST_BYTES);
    endfunction

    // Strobes decode straight from state so each one sees the current-cycle
    // flow-control flag; everything else is registered in the FSM.
    always_comb begin
        wr_en    = (state == ST_FILL) && !wr_full;
        cmd_en   = ((state == ST_WR_CMD) || (state == ST_RD_CMD)) && !cmd_full;
        rd_en    = (state == ST_DRAIN) && !rd_empty;
        start_ok = (state == ST_IDLE) && start;
        loop_ok  = (state == ST_END) && mode_cont && !timeout;
        wr_seed  = start_ok || loop_ok;
        rd_seed  = (state == ST_WR_CMD) && cmd_en && (idx == LAST_IDX);
        gen_sel  = (state == ST_IDLE) ? pattern_sel : mode_lfsr;
        mismatch = rd_data != {REPS{exp_word}};
        wr_data  = {REPS{wr_word}};
        wr_mask  = '0;
    end

    pattern_gen u_wr_gen (
        .clk   (clk),
        .reset (reset),
        .seed  (wr_seed),
        .step  (wr_en),
        .sel   (gen_sel),
        .word  (wr_word)
    );

    pattern_gen u_rd_gen (
        .clk   (clk),
        .reset (reset),
        .seed  (rd_seed),
        .step  (rd_en),
        .sel   (gen_sel),
        .word  (exp_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_CALIB;
            calib_s1       <= 1'b0;
            calib_s2       <= 1'b0;
            idx            <= '0;
            wcnt           <= '0;
            to_cnt         <= '0;
            mode_cont      <= 1'b0;
            mode_lfsr      <= 1'b0;
            have_err       <= 1'b0;
            cmd_instr      <= '0;
            cmd_bl         <= '0;
            cmd_byte_addr  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            calib_s1 <= calib_done;
            calib_s2 <= calib_s1;
            done     <= 1'b0;
            case (state)
                ST_CALIB: begin
                    if (calib_s2) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (start) begin
                        mode_cont      <= continuous;
                        mode_lfsr      <= pattern_sel;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        have_err       <= 1'b0;
                        timeout        <= 1'b0;
                        pass           <= 1'b1;
                        busy           <= 1'b1;
                        idx            <= '0;
                        wcnt           <= '0;
                        state          <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (wr_en) begin
                        if (wcnt == LAST_WORD) begin
                            wcnt          <= '0;
                            cmd_instr     <= INSTR_WR;
                            cmd_bl        <= 6'(BURST_LEN - 1);
                            cmd_byte_addr <= burst_addr(idx);
                            state         <= ST_WR_CMD;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                ST_WR_CMD: begin
                    if (cmd_en) begin
                        if (idx == LAST_IDX) begin
                            idx           <= '0;
                            cmd_instr     <= INSTR_RD;
                            cmd_byte_addr <= burst_addr('0);
                            state         <= ST_RD_CMD;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_FILL;
                        end
                    end
                end
                ST_RD_CMD: begin
                    if (cmd_en) begin
                        wcnt   <= '0;
                        to_cnt <= '0;
                        state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd_en) begin
                        to_cnt <= '0;
                        if (mismatch) begin
                            pass <= 1'b0;
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            if (!have_err) begin
                                have_err       <= 1'b1;
                                first_err_addr <= burst_addr(idx) + 30'(wcnt) * 30'(WORD_BYTES);
                            end
                        end
                        if (wcnt == LAST_WORD) begin
                            wcnt <= '0;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                done  <= 1'b1;
                                state <= ST_END;
                            end else begin
                                idx           <= idx + 1'b1;
                                cmd_byte_addr <= burst_addr(idx + 1'b1);
                                state         <= ST_RD_CMD;
                            end
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_END;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_END: begin
                    if (mode_cont && !timeout) begin
                        state <= ST_FILL;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_CALIB;
            endcase
        end
    end

endmodule
